// File: rtl/reg_scoreboard.sv
// Register scoreboard for in-flight long-latency ops (loads, mul/div).
// Raises the ID stall when a source or destination is still pending.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_rs1/id_rs2     ID source registers, qualified by id_rs*_used
//   id_rd             ID destination, qualified by id_reg_write
//   id_long_lat       ID op completes through a long-latency unit
//   id_issue          ID instruction valid and leaving ID this cycle
//   wb_valid/wb_rd    long-latency writeback this cycle
//   stall             combinational hold for ID/IF
//   rs1/rs2_hazard    stall causes: source operand pending
//   pending_mask      registered pending bit per register
//   outstanding       registered count of in-flight ops
//   err_sticky        writeback to a non-pending register seen
module reg_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_long_lat,
    input  logic                  id_issue,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall,
    output logic                  rs1_hazard,
    output logic                  rs2_hazard,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  err_sticky
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    logic                wb_pend;
    logic                waw;
    logic                full;
    logic                acc;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    // A pending register being written back this cycle is covered by
    // MEM/WB forwarding, so it no longer counts as a hazard.
    assign wb_pend = wb_valid && pending_mask[wb_rd];

    assign rs1_hazard = id_rs1_used && (id_rs1 != X0)
                     && pending_mask[id_rs1]
                     && !(wb_pend && (wb_rd == id_rs1));

    assign rs2_hazard = id_rs2_used && (id_rs2 != X0)
                     && pending_mask[id_rs2]
                     && !(wb_pend && (wb_rd == id_rs2));

    assign waw = id_reg_write && (id_rd != X0)
              && pending_mask[id_rd]
              && !(wb_pend && (wb_rd == id_rd));

    // A completing op frees a slot in the same cycle.
    assign full = id_long_lat && id_reg_write
               && (outstanding == MAX_C) && !wb_pend;

    assign stall = rs1_hazard | rs2_hazard | waw | full;

    assign acc = id_issue && !stall && id_reg_write
              && id_long_lat && (id_rd != X0);

    // Set wins over clear so a WAW reissue on the completing register
    // stays tracked.
    always_comb begin
        pending_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_nxt[i] =
                (pending_mask[i]
                 && !(wb_pend && (wb_rd == REG_ADDR_W'(i))))
                || (acc && (id_rd == REG_ADDR_W'(i)));
        end
    end

    assign cnt_nxt = outstanding + CNT_W'(acc) - CNT_W'(wb_pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_mask <= '0;
            outstanding  <= '0;
            err_sticky   <= 1'b0;
        end else begin
            pending_mask <= pending_nxt;
            outstanding  <= cnt_nxt;
            if (wb_valid && !pending_mask[wb_rd])
                err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard.
// Inputs change 1ns after posedge; outputs sampled before the next edge.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_rs1_used, id_rs2_used;
    logic        id_reg_write, id_long_lat, id_issue, wb_valid;
    logic        stall, rs1_hazard, rs2_hazard, err_sticky;
    logic [31:0] pending_mask;
    logic [2:0]  outstanding;

    int tests = 0;
    int fails = 0;

    reg_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_long_lat  (id_long_lat),
        .id_issue     (id_issue),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .stall        (stall),
        .rs1_hazard   (rs1_hazard),
        .rs2_hazard   (rs2_hazard),
        .pending_mask (pending_mask),
        .outstanding  (outstanding),
        .err_sticky   (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_reg_write = 0; id_long_lat = 0; id_issue = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic long_issue(input logic [4:0] rd);
        id_rd = rd; id_reg_write = 1; id_long_lat = 1; id_issue = 1;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1; wb_rd = rd;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #3;
        chk("rst_mask", pending_mask, 0);
        chk("rst_cnt", 32'(outstanding), 0);
        chk("rst_err", 32'(err_sticky), 0);
        chk("rst_stall", 32'(stall), 0);
        #4 rst_n = 1;
        tick();

        // 1: load x5 then dependent use, cleared by same-cycle wb
        long_issue(5);
        #1 chk("t1_issue_stall", 32'(stall), 0);
        tick(); idle();
        chk("t1_mask", pending_mask, 32'h20);
        chk("t1_cnt", 32'(outstanding), 1);
        id_rs1 = 5; id_rs1_used = 1;
        #1 chk("t1_stall", 32'(stall), 1);
        chk("t1_rs1hz", 32'(rs1_hazard), 1);
        chk("t1_rs2hz", 32'(rs2_hazard), 0);
        wb(5);
        #1 chk("t1_wb_stall", 32'(stall), 0);
        chk("t1_wb_rs1hz", 32'(rs1_hazard), 0);
        tick(); idle();
        chk("t1_clr_mask", pending_mask, 0);
        chk("t1_clr_cnt", 32'(outstanding), 0);
        chk("t1_err", 32'(err_sticky), 0);

        // 2: x0 never tracked
        id_rs1_used = 1; id_rs2_used = 1;
        long_issue(0);
        #1 chk("t2_stall", 32'(stall), 0);
        tick(); idle();
        chk("t2_mask", pending_mask, 0);
        chk("t2_cnt", 32'(outstanding), 0);

        // 3: fill to 4, full stall, relieved by same-cycle wb
        for (int r = 1; r <= 4; r++) begin
            long_issue(r[4:0]);
            tick();
        end
        idle();
        chk("t3_fill_mask", pending_mask, 32'h1E);
        chk("t3_fill_cnt", 32'(outstanding), 4);
        long_issue(10);
        #1 chk("t3_full_stall", 32'(stall), 1);
        chk("t3_full_rs1hz", 32'(rs1_hazard), 0);
        tick();
        chk("t3_ign_mask", pending_mask, 32'h1E);
        chk("t3_ign_cnt", 32'(outstanding), 4);
        wb(1);
        #1 chk("t3_wb_stall", 32'(stall), 0);
        tick(); idle();
        chk("t3_acc_mask", pending_mask, 32'h41C);
        chk("t3_acc_cnt", 32'(outstanding), 4);
        wb(2); tick();
        wb(3); tick();
        wb(4); tick();
        wb(10); tick(); idle();
        chk("t3_drain_mask", pending_mask, 0);
        chk("t3_drain_cnt", 32'(outstanding), 0);
        chk("t3_err", 32'(err_sticky), 0);

        // 4: WAW on x7, rs2 hazard, non-long issue no-op
        long_issue(7);
        tick(); idle();
        chk("t4_mask", pending_mask, 32'h80);
        id_rs2 = 7; id_rs2_used = 1;
        #1 chk("t4_rs2hz", 32'(rs2_hazard), 1);
        chk("t4_rs2_stall", 32'(stall), 1);
        idle();
        id_rd = 12; id_reg_write = 1; id_issue = 1;
        #1 chk("t4_short_stall", 32'(stall), 0);
        tick(); idle();
        chk("t4_short_mask", pending_mask, 32'h80);
        chk("t4_short_cnt", 32'(outstanding), 1);
        long_issue(7);
        #1 chk("t4_waw_stall", 32'(stall), 1);
        wb(7);
        #1 chk("t4_waw_wb_stall", 32'(stall), 0);
        tick(); idle();
        chk("t4_reacc_mask", pending_mask, 32'h80);
        chk("t4_reacc_cnt", 32'(outstanding), 1);
        wb(7); tick(); idle();
        chk("t4_done_mask", pending_mask, 0);
        chk("t4_done_cnt", 32'(outstanding), 0);

        // 5: spurious writeback
        wb(9); tick(); idle();
        chk("t5_err", 32'(err_sticky), 1);
        chk("t5_mask", pending_mask, 0);
        chk("t5_cnt", 32'(outstanding), 0);
        tick();
        chk("t5_err_hold", 32'(err_sticky), 1);

        // 6: async reset mid-flight
        for (int r = 1; r <= 3; r++) begin
            long_issue(r[4:0]);
            tick();
        end
        idle();
        chk("t6_cnt", 32'(outstanding), 3);
        chk("t6_mask", pending_mask, 32'hE);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_mask", pending_mask, 0);
        chk("t6_rst_cnt", 32'(outstanding), 0);
        chk("t6_rst_err", 32'(err_sticky), 0);
        #1 rst_n = 1;
        tick();
        wb(1); tick(); idle();
        chk("t6_late_err", 32'(err_sticky), 1);
        chk("t6_late_cnt", 32'(outstanding), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
